bch_ecc_dual_bit_decoder: RTL



---
 rtl/bch_ecc_dual_bit_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bch_ecc_dual_bit_decoder.sv
// HDMI data island subpacket BCH(64,56) receive decoder, 2 bits per pixel clock.
// Define BCH_ECC_CORRECT_EN to build in single-bit correction; otherwise detection only.
module bch_ecc_dual_bit_decoder #(
  parameter int ALLOW_STALL = 1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [1:0]  dataIn,
  input  logic        valid,
  input  logic        isFirstDataClock,
  output logic [55:0] subpacket,
  output logic [7:0]  parity,
  output logic [7:0]  syndrome,
  output logic        done,
  output logic        errorDetected,
  output logic        errorCorrected,
  output logic        uncorrectable
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, REPORT} state_t;

  // Right-shifting Galois form of x^8+x^7+x^6+1, matching the transmit encoder.
  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  ecc_q, ecc_d, ecc_pair;
  logic [55:0] rx_sub_q, rx_sub_d, sub_q, sub_d;
  logic [7:0]  rx_par_q, rx_par_d, par_q, par_d;
  logic [7:0]  syn_q, syn_d;
  logic [63:0] flip;
  logic        hit;

`ifdef BCH_ECC_CORRECT_EN
  typedef logic [63:0][7:0] sig_t;

  // Entry k<56: syndrome of a lone data bit k; entry 56+j: lone parity bit j.
  function automatic sig_t make_sigs();
    sig_t       s;
    logic [7:0] e;
    for (int k = 0; k < 56; k++) begin
      e = 8'h00;
      for (int i = 0; i < 56; i++) e = ecc_step(e, i == k);
      s[k] = e;
    end
    for (int j = 0; j < 8; j++) s[56+j] = 8'(1 << j);
    return s;
  endfunction

  localparam sig_t SIGS = make_sigs();

  always_comb begin
    flip = 64'd0;
    hit  = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (!hit && state_q == REPORT && syn_q != 8'h00 && SIGS[p] == syn_q) begin
        flip[p] = 1'b1;
        hit     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    flip = 64'd0;
    hit  = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ecc_d    = ecc_q;
    rx_sub_d = rx_sub_q;
    rx_par_d = rx_par_q;
    sub_d    = sub_q;
    par_d    = par_q;
    syn_d    = syn_q;
    ecc_pair = ecc_step(ecc_step(ecc_q, dataIn[0]), dataIn[1]);
    // Commit any correction so held outputs stay repaired after the pulse.
    if (state_q == REPORT) begin
      sub_d   = subpacket;
      par_d   = parity;
      state_d = IDLE;
    end
    if (valid && isFirstDataClock) begin
      rx_sub_d = {54'd0, dataIn};
      rx_par_d = 8'h00;
      ecc_d    = ecc_step(ecc_step(8'h00, dataIn[0]), dataIn[1]);
      cnt_d    = 5'd1;
      state_d  = DATA;
    end else begin
      case (state_q)
        DATA: begin
          if (valid) begin
            rx_sub_d[{cnt_q, 1'b0} +: 2] = dataIn;
            ecc_d = ecc_pair;
            if (cnt_q == 5'd27) begin
              cnt_d   = 5'd0;
              state_d = PARITY;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else if (ALLOW_STALL == 0) begin
            cnt_d   = 5'd0;
            state_d = IDLE;
          end
        end
        PARITY: begin
          if (valid) begin
            rx_par_d[{cnt_q[1:0], 1'b0} +: 2] = dataIn;
            if (cnt_q == 5'd3) begin
              cnt_d   = 5'd0;
              state_d = REPORT;
              sub_d   = rx_sub_q;
              par_d   = rx_par_d;
              syn_d   = ecc_q ^ rx_par_d;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else if (ALLOW_STALL == 0) begin
            cnt_d   = 5'd0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      ecc_q    <= 8'h00;
      rx_sub_q <= 56'd0;
      rx_par_q <= 8'h00;
      sub_q    <= 56'd0;
      par_q    <= 8'h00;
      syn_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ecc_q    <= ecc_d;
      rx_sub_q <= rx_sub_d;
      rx_par_q <= rx_par_d;
      sub_q    <= sub_d;
      par_q    <= par_d;
      syn_q    <= syn_d;
    end
  end

  assign done           = (state_q == REPORT);
  assign subpacket      = sub_q ^ flip[55:0];
  assign parity         = par_q ^ flip[63:56];
  assign syndrome       = syn_q;
  assign errorDetected  = done && (syn_q != 8'h00);
  assign errorCorrected = done && hit;
  assign uncorrectable  = errorDetected && !hit;

endmodule
